// File: rtl/uart_prog_loader.sv
// UART boot loader: 8N1 receiver feeding a header/word parser that issues one
// instruction-memory write per assembled little-endian 32-bit word.
module uart_prog_loader #(
    parameter int unsigned CLK_HZ = 10_000_000,
    parameter int unsigned BAUD   = 115_200,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              rx_i,
    input  logic              start_i,
    output logic              upg_rst_o,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              frame_err_o
);

    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    // Word-count limit 2**ADDR_W; ADDR_W must not exceed 16 (16-bit header).
    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {RX_WAIT, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {ST_IDLE, ST_HDR0, ST_HDR1, ST_DATA, ST_DONE} ld_state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_vld;
    logic             stop_bad;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_state_q <= RX_WAIT;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_vld   = 1'b0;
        stop_bad   = 1'b0;
        case (rx_state_q)
            RX_WAIT: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // Mid-start-bit check rejects line glitches shorter than half a bit.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_WAIT : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_WAIT;
                    byte_vld   = rx_sync_q;
                    stop_bad   = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_WAIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    ld_state_t         state_q, state_d;
    logic [7:0]        hdr_lo_q, hdr_lo_d;
    logic [ADDR_W:0]   nwords_q, nwords_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]   cnt_inc;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_buf_q, word_buf_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic              wen_q, wen_d;
    logic              done_q, done_d;
    logic              rst_q, rst_d;
    logic              ferr_q, ferr_d;
    logic [15:0]       hdr;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            hdr_lo_q   <= '0;
            nwords_q   <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            word_buf_q <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            wen_q      <= 1'b0;
            done_q     <= 1'b0;
            rst_q      <= 1'b1;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_lo_q   <= hdr_lo_d;
            nwords_q   <= nwords_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            wen_q      <= wen_d;
            done_q     <= done_d;
            rst_q      <= rst_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hdr_lo_d   = hdr_lo_q;
        nwords_d   = nwords_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        wen_d      = 1'b0;
        done_d     = done_q;
        rst_d      = rst_q;
        ferr_d     = ferr_q;
        cnt_inc    = word_cnt_q + (ADDR_W + 1)'(1);
        hdr        = {rx_shift_q, hdr_lo_q};

        if (start_i) begin
            // Restart wins over any byte arriving in the same cycle.
            state_d    = ST_HDR0;
            word_cnt_d = '0;
            byte_idx_d = '0;
            adr_d      = '0;
            done_d     = 1'b0;
            ferr_d     = 1'b0;
            rst_d      = 1'b0;
        end else begin
            if (stop_bad && state_q != ST_IDLE) begin
                ferr_d = 1'b1;
            end
            if (wen_q) begin
                adr_d      = adr_q + ADDR_W'(1);
                word_cnt_d = cnt_inc;
                if (cnt_inc == nwords_q) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            case (state_q)
                ST_HDR0: begin
                    if (byte_vld) begin
                        hdr_lo_d = rx_shift_q;
                        state_d  = ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (byte_vld) begin
                        byte_idx_d = '0;
                        if (hdr == 16'd0) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            nwords_d = (32'(hdr) > 32'(MAX_WORDS)) ? MAX_WORDS
                                                                    : (ADDR_W + 1)'(hdr);
                            state_d  = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (byte_vld) begin
                        word_buf_d[{byte_idx_q, 3'b000} +: 8] = rx_shift_q;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            wen_d = 1'b1;
                            dat_d = {rx_shift_q, word_buf_q[23:0]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign upg_rst_o   = rst_q;
    assign upg_wen_o   = wen_q;
    assign upg_adr_o   = adr_q;
    assign upg_dat_o   = dat_q;
    assign upg_done_o  = done_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: serial byte driver, write monitor feeding an
// observed queue, and per-scenario tasks comparing against expected writes.
`timescale 1ns/1ps
module tb_uart_prog_loader;

    localparam int CLK_HZ = 921_600;
    localparam int BAUD   = 115_200;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int AW     = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          start = 1'b0;
    logic          upg_rst, upg_wen, upg_done, ferr;
    logic [AW-1:0] upg_adr;
    logic [31:0]   upg_dat;

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW-1:0] exp_adr[$];
    logic [31:0]   exp_dat[$];
    logic [AW-1:0] obs_adr[$];
    logic [31:0]   obs_dat[$];
    logic          prev_wen = 1'b0;
    logic          b2b_seen = 1'b0;

    uart_prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(AW)) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .rx_i       (rx),
        .start_i    (start),
        .upg_rst_o  (upg_rst),
        .upg_wen_o  (upg_wen),
        .upg_adr_o  (upg_adr),
        .upg_dat_o  (upg_dat),
        .upg_done_o (upg_done),
        .frame_err_o(ferr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upg_wen) begin
            obs_adr.push_back(upg_adr);
            obs_dat.push_back(upg_dat);
            $display("write adr=%0h dat=%08h", upg_adr, upg_dat);
        end
        if (upg_wen && prev_wen) b2b_seen = 1'b1;
        prev_wen = upg_wen;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(DIV);
        end
        rx = stop_v;
        idle(DIV);
        rx = 1'b1;
        if (!stop_v) idle(DIV);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a, input bit expect_it);
        if (expect_it) begin
            exp_adr.push_back(a);
            exp_dat.push_back(w);
        end
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle(1);
        start = 1'b0;
        exp_adr.delete();
        exp_dat.delete();
        obs_adr.delete();
        obs_dat.delete();
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({upg_rst, upg_wen, upg_adr, upg_dat, upg_done, ferr} !== {1'b1, 1'b0, {AW{1'b0}}, 32'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got rst=%b wen=%b adr=%h dat=%h done=%b ferr=%b want 1 0 0 0 0 0",
                     upg_rst, upg_wen, upg_adr, upg_dat, upg_done, ferr);
        end
    endtask

    task automatic test_no_start();
        obs_adr.delete();
        obs_dat.delete();
        for (int i = 0; i < 6; i++) send_byte(8'h11 * i[7:0] + 8'h02, 1'b1);
        idle(2 * DIV);
        n_cmp++;
        if (obs_adr.size() !== 0) begin
            n_bad++;
            $display("FAIL no_start_writes: got %0d want 0", obs_adr.size());
        end
        n_cmp++;
        if ({upg_rst, upg_done} !== 2'b10) begin
            n_bad++;
            $display("FAIL no_start_rst: got rst=%b done=%b want 1 0", upg_rst, upg_done);
        end
    endtask

    task automatic test_basic();
        pulse_start();
        n_cmp++;
        if (upg_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_rst_low: got %b want 0", upg_rst);
        end
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h12345678, 0, 1);
        n_cmp++;
        if (obs_adr.size() !== 1 || upg_done !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_first_word: got writes=%0d done=%b want 1 0", obs_adr.size(), upg_done);
        end
        send_word(32'hDEADBEEF, 1, 1);
        idle(2 * DIV);
        n_cmp++;
        if (obs_adr.size() !== exp_adr.size()) begin
            n_bad++;
            $display("FAIL basic_count: got %0d want %0d", obs_adr.size(), exp_adr.size());
        end
        while (obs_adr.size() > 0 && exp_adr.size() > 0) begin
            automatic logic [AW-1:0] ea = exp_adr.pop_front();
            automatic logic [31:0]   ed = exp_dat.pop_front();
            automatic logic [AW-1:0] oa = obs_adr.pop_front();
            automatic logic [31:0]   od = obs_dat.pop_front();
            n_cmp++;
            if (oa !== ea || od !== ed) begin
                n_bad++;
                $display("FAIL basic_write: got %h:%08h want %h:%08h", oa, od, ea, ed);
            end
        end
        n_cmp++;
        if ({upg_done, upg_rst, ferr} !== 3'b100) begin
            n_bad++;
            $display("FAIL basic_done: got done=%b rst=%b ferr=%b want 1 0 0", upg_done, upg_rst, ferr);
        end
    endtask

    task automatic test_zero_header();
        pulse_start();
        n_cmp++;
        if (upg_done !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_done_cleared: got %b want 0", upg_done);
        end
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(4);
        n_cmp++;
        if (upg_done !== 1'b1 || obs_adr.size() !== 0) begin
            n_bad++;
            $display("FAIL zero_header: got done=%b writes=%0d want 1 0", upg_done, obs_adr.size());
        end
    endtask

    task automatic test_clamp();
        b2b_seen = 1'b0;
        pulse_start();
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        for (int i = 0; i < (1 << AW); i++) send_word($urandom, i[AW-1:0], 1);
        idle(2 * DIV);
        n_cmp++;
        if (upg_done !== 1'b1) begin
            n_bad++;
            $display("FAIL clamp_done: got %b want 1", upg_done);
        end
        send_word(32'hCAFEF00D, 0, 0);
        idle(2 * DIV);
        n_cmp++;
        if (obs_adr.size() !== exp_adr.size()) begin
            n_bad++;
            $display("FAIL clamp_count: got %0d want %0d", obs_adr.size(), exp_adr.size());
        end
        while (obs_adr.size() > 0 && exp_adr.size() > 0) begin
            automatic logic [AW-1:0] ea = exp_adr.pop_front();
            automatic logic [31:0]   ed = exp_dat.pop_front();
            automatic logic [AW-1:0] oa = obs_adr.pop_front();
            automatic logic [31:0]   od = obs_dat.pop_front();
            n_cmp++;
            if (oa !== ea || od !== ed) begin
                n_bad++;
                $display("FAIL clamp_write: got %h:%08h want %h:%08h", oa, od, ea, ed);
            end
        end
        n_cmp++;
        if (b2b_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL back_to_back: got adjacent strobes=%b want 0", b2b_seen);
        end
    endtask

    task automatic test_frame_err();
        pulse_start();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        exp_adr.push_back(0);
        exp_dat.push_back(32'h44332211);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        n_cmp++;
        if (ferr !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_err_pre: got %b want 0", ferr);
        end
        send_byte(8'h99, 1'b0);
        n_cmp++;
        if (ferr !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_err_set: got %b want 1", ferr);
        end
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle(2 * DIV);
        n_cmp++;
        if (obs_adr.size() !== 1 || upg_done !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_count: got writes=%0d done=%b want 1 1", obs_adr.size(), upg_done);
        end
        if (obs_adr.size() > 0) begin
            n_cmp++;
            if (obs_adr[0] !== exp_adr[0] || obs_dat[0] !== exp_dat[0]) begin
                n_bad++;
                $display("FAIL frame_write: got %h:%08h want %h:%08h", obs_adr[0], obs_dat[0], exp_adr[0], exp_dat[0]);
            end
        end
    endtask

    task automatic test_restart();
        logic [AW-1:0] ea[$];
        logic [31:0]   ed[$];
        pulse_start();
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'hA1A2A3A4, 0, 1);
        send_word(32'hB1B2B3B4, 1, 1);
        send_byte(8'hC1, 1'b1);
        send_byte(8'hC2, 1'b1);
        ea = exp_adr;
        ed = exp_dat;
        start = 1'b1;
        idle(1);
        start = 1'b0;
        n_cmp++;
        if ({upg_done, upg_rst, ferr} !== 3'b000) begin
            n_bad++;
            $display("FAIL restart_flags: got done=%b rst=%b ferr=%b want 0 0 0", upg_done, upg_rst, ferr);
        end
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        exp_adr = ea;
        exp_dat = ed;
        send_word(32'hD1D2D3D4, 0, 1);
        idle(2 * DIV);
        n_cmp++;
        if (obs_adr.size() !== exp_adr.size() || upg_done !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_count: got writes=%0d done=%b want %0d 1", obs_adr.size(), upg_done, exp_adr.size());
        end
        while (obs_adr.size() > 0 && exp_adr.size() > 0) begin
            automatic logic [AW-1:0] a_e = exp_adr.pop_front();
            automatic logic [31:0]   d_e = exp_dat.pop_front();
            automatic logic [AW-1:0] a_o = obs_adr.pop_front();
            automatic logic [31:0]   d_o = obs_dat.pop_front();
            n_cmp++;
            if (a_o !== a_e || d_o !== d_e) begin
                n_bad++;
                $display("FAIL restart_write: got %h:%08h want %h:%08h", a_o, d_o, a_e, d_e);
            end
        end
    endtask

    task automatic test_glitch();
        pulse_start();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        rx = 1'b0;
        idle(DIV / 2);
        rx = 1'b1;
        idle(2 * DIV);
        send_word(32'h0BADF00D, 0, 1);
        idle(2 * DIV);
        n_cmp++;
        if (obs_adr.size() !== 1 || upg_done !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_count: got writes=%0d done=%b want 1 1", obs_adr.size(), upg_done);
        end
        if (obs_adr.size() > 0) begin
            n_cmp++;
            if (obs_adr[0] !== exp_adr[0] || obs_dat[0] !== exp_dat[0]) begin
                n_bad++;
                $display("FAIL glitch_write: got %h:%08h want %h:%08h", obs_adr[0], obs_dat[0], exp_adr[0], exp_dat[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h55AA33CC, 0, 1);
        idle(2);
        n_cmp++;
        if (upg_adr !== 1 || upg_dat !== 32'h55AA33CC) begin
            n_bad++;
            $display("FAIL reset_mid_pre: got %h:%08h want 1:55aa33cc", upg_adr, upg_dat);
        end
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        rx = 1'b0;
        idle(3 * DIV);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({upg_rst, upg_wen, upg_adr, upg_dat, upg_done, ferr} !== {1'b1, 1'b0, {AW{1'b0}}, 32'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid_state: got rst=%b wen=%b adr=%h dat=%h done=%b ferr=%b want 1 0 0 0 0 0",
                     upg_rst, upg_wen, upg_adr, upg_dat, upg_done, ferr);
        end
        rx = 1'b1;
        idle(4);
        rst_n = 1'b1;
        idle(2 * DIV);
        obs_adr.delete();
        obs_dat.delete();
        send_word(32'h01020304, 0, 0);
        idle(2 * DIV);
        n_cmp++;
        if (obs_adr.size() !== 0 || upg_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_after: got writes=%0d rst=%b want 0 1", obs_adr.size(), upg_rst);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(5);
        rst_n = 1'b1;
        idle(2);
        test_reset();
        test_no_start();
        test_basic();
        test_zero_header();
        test_clamp();
        test_frame_err();
        test_restart();
        test_glitch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
